mem_access_ctrl: RTL
====================

# mem_access_ctrl

Load/store initiator that sits between the CPU datapath and the 32-bit byte-banked data memory (`Memoria32`). It turns one CPU request (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-aligned memory transactions. Sub-word stores are done by read-modify-write. Load data is extracted and sign- or zero-extended. The memory's banks stay coherent only if every access uses a word-aligned address, so this block never issues an unaligned address.

## Interface
- No parameters. Data width is fixed at 32 bits and memory read latency is fixed at 1 cycle.
- Clk  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- Req  in  1  request strobe, sampled only in IDLE
- Store  in  1  1 = store, 0 = load
- Size  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- Addr  in  32  byte address
- WData  in  32  store data; low byte, half or word used
- RData  out  32  extended load result; holds its value until the next load completes
- Done  out  1  one-cycle completion pulse
- Err  out  1  valid with Done: misaligned access or illegal Size
- Busy  out  1  high whenever the state is not IDLE
- MemRAddr  out  32  memory read address, always {A[31:2],2'b00}
- MemWAddr  out  32  memory write address, always {A[31:2],2'b00}
- MemDataout  out  32  word driven to memory Datain
- MemDatain  in  32  word from memory Dataout; registered read, valid 1 cycle after MemRAddr
- MemWr  out  1  memory write enable

## Operation
- **States:** IDLE, READ, CAPTURE, WRITE, FINISH.
- **Latching:** in IDLE, Req=1 latches Store, Size, Addr and WData. Off = Addr[1:0].
- **Illegal requests → FINISH with Err=1.** A request is illegal when:
  - Size is 011, 110 or 111;
  - Store=1 and Size[2]=1;
  - Size is H or HU and Off[0]=1;
  - Size is W and Off≠0.
  - No memory access occurs and RData is unchanged.
- **Transitions:**
  - Load: IDLE → READ → CAPTURE → FINISH.
  - SW: IDLE → WRITE → FINISH. MemDataout = WData.
  - SB/SH: IDLE → READ → CAPTURE → WRITE → FINISH.
- **Lane mapping:** little-endian; byte k = word[8k+7:8k].
- **Load extraction in CAPTURE:**
  - B/BU take byte Off.
  - H/HU take bytes Off+1:Off.
  - B and H sign-extend; BU and HU zero-extend.
  - The result is registered into RData.
- **Store merge in CAPTURE:**
  - SB replaces byte Off with WData[7:0].
  - SH replaces bytes Off+1:Off with WData[15:0].
  - All other bytes come from MemDatain.
  - The merged word is registered and drives MemDataout in WRITE.
- **MemWr:** high only in WRITE, for exactly one cycle per store.
- **FINISH:** Done=1 for that cycle, then return to IDLE.
- **Busy requests:** Req while Busy=1 is ignored and not queued.
- **Back-to-back:** a new Req may be sampled in the cycle after Done, since the state is then IDLE.
- **Mid-operation reset:** Reset forces IDLE at the next edge. No later MemWr and no Done for the aborted request. If Reset is sampled in WRITE, the write in that same edge still occurs; this is allowed.

## Timing
- Request accepted at edge 0, so state at cycle 1 is the first state after IDLE.
- **LB/LH/LW/LBU/LHU:**
  - READ in cycle 1; MemRAddr valid.
  - MemDatain valid in cycle 2 (CAPTURE).
  - Done and RData valid in cycle 3.
- **SW:** MemWr in cycle 1; Done in cycle 2.
- **SB/SH:** READ in cycle 1, CAPTURE in cycle 2, MemWr in cycle 3, Done in cycle 4.
- **Error:** Done=Err=1 in cycle 1.
- **Reset values:**
  - State = IDLE.
  - RData = 0, MemRAddr = 0, MemWAddr = 0, MemDataout = 0.
  - Done = 0, Err = 0, Busy = 0, MemWr = 0.
- **Output registering:** all outputs are registered except Busy, which is decoded from the state register. MemRAddr and MemWAddr hold their last value while in IDLE.

## Test plan
- **Loads:** memory word 0x100 = 0xA1B2C3D4.
  - LB 0x103 → RData 0xFFFFFFA1
  - LBU 0x103 → 0x000000A1
  - LH 0x102 → 0xFFFFA1B2
  - LHU 0x100 → 0x0000C3D4
  - LW 0x100 → 0xA1B2C3D4
  - For each: Done in cycle 3 and MemRAddr = 0x100.
- **SB:** SB 0x101 with WData 0xFFFFFF55 on the same word → a single MemWr in cycle 3 with MemDataout 0xA1B255D4 at MemWAddr 0x100. A subsequent LW 0x100 returns 0xA1B255D4.
- **SH then SW:**
  - SH 0x102 with WData 0x00001234 → word becomes 0x1234C3D4; Done in cycle 4.
  - SW 0x104 with WData 0xDEADBEEF → MemWr in cycle 1; Done in cycle 2.
- **Errors:**
  - LW 0x102 → Done=Err=1 in cycle 1, MemWr never asserted, RData unchanged.
  - Size 011 → Err=1.
  - SB with Size 100 → Err=1.
- **Reset mid-SB:** assert Reset during CAPTURE of an SB → MemWr stays 0, no Done, Busy=0 after the edge, memory word unchanged.
- **Req while busy:** pulse Req with a different Addr during READ of an LW → ignored; only one Done. A Req in the cycle after Done is accepted.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Load/store initiator between the CPU datapath and a 32-bit byte-banked data
// memory. It turns one CPU request into word-aligned memory transactions.
// Sub-word stores use read-modify-write. Load data is extracted from the word
// and then sign- or zero-extended. The block never issues an unaligned address.
//
// Ports
//   clk_i          system clock, rising edge
//   reset_i        synchronous active-high reset
//   req_i          request strobe, sampled only in IDLE
//   store_i        1 = store, 0 = load
//   size_i[2:0]    funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_i[31:0]   byte address
//   wdata_i[31:0]  store data (low byte, half or word used)
//   rdata_o[31:0]  extended load result, held until the next load completes
//   done_o         one-cycle completion pulse
//   err_o          valid with done_o: misaligned access or illegal size
//   busy_o         high whenever the FSM is not in IDLE
//   mem_raddr_o    word-aligned memory read address
//   mem_waddr_o    word-aligned memory write address
//   mem_dataout_o  word driven to the memory data input
//   mem_datain_i   registered memory read data, valid 1 cycle after the address
//   mem_wr_o       memory write enable
module mem_access_ctrl (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        store_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        busy_o,
  output logic [31:0] mem_raddr_o,
  output logic [31:0] mem_waddr_o,
  output logic [31:0] mem_dataout_o,
  input  logic [31:0] mem_datain_i,
  output logic        mem_wr_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_FINISH
  } state_e;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;
  // Only the low half of the store data is needed after acceptance: SW
  // forwards wdata_i straight to the memory in the accepting cycle.
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] raddr_q, raddr_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] dataout_q, dataout_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        wr_q, wr_d;

  logic        illegal;
  logic [4:0]  byte_shift;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;
  logic [31:0] st_mask;
  logic [31:0] st_data;
  logic [31:0] merged;

  // Request legality is judged on the live inputs in IDLE so an illegal
  // request goes straight to FINISH without touching memory.
  always_comb begin
    illegal = 1'b0;
    case (size_i)
      SZ_B, SZ_BU: illegal = 1'b0;
      SZ_H, SZ_HU: illegal = addr_i[0];
      SZ_W:        illegal = (addr_i[1:0] != 2'b00);
      default:     illegal = 1'b1;
    endcase
    if (store_i && size_i[2]) illegal = 1'b1;
  end

  // Little-endian lanes: byte k lives at word[8k+7:8k]. Halves are only
  // legal at offsets 0 and 2, so off_q[1] selects the half.
  assign byte_shift = {off_q, 3'b000};
  assign lane_byte  = mem_datain_i[byte_shift +: 8];
  assign lane_half  = mem_datain_i[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      SZ_B:    load_ext = {{24{lane_byte[7]}}, lane_byte};
      SZ_H:    load_ext = {{16{lane_half[15]}}, lane_half};
      SZ_BU:   load_ext = {24'h0, lane_byte};
      SZ_HU:   load_ext = {16'h0, lane_half};
      default: load_ext = mem_datain_i;
    endcase
  end

  // Replicating the store data across lanes lets one mask pick the target
  // bytes; everything outside the mask comes from the word just read.
  assign st_mask = (size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << byte_shift;
  assign st_data = size_q[0] ? {2{wdata_q}} : {4{wdata_q[7:0]}};
  assign merged  = (mem_datain_i & ~st_mask) | (st_data & st_mask);

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    store_d   = store_q;
    size_d    = size_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    dataout_d = dataout_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          store_d = store_i;
          size_d  = size_i;
          off_d   = addr_i[1:0];
          wdata_d = wdata_i[15:0];
          if (illegal) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            raddr_d = {addr_i[31:2], 2'b00};
            waddr_d = {addr_i[31:2], 2'b00};
            if (store_i && (size_i == SZ_W)) begin
              dataout_d = wdata_i;
              wr_d      = 1'b1;
              state_d   = S_WRITE;
            end else begin
              state_d = S_READ;
            end
          end
        end
      end
      // Memory is registering the read address during this cycle.
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (store_q) begin
          dataout_d = merged;
          wr_d      = 1'b1;
          state_d   = S_WRITE;
        end else begin
          rdata_d = load_ext;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_WRITE: begin
        done_d  = 1'b1;
        state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      store_q   <= 1'b0;
      size_q    <= 3'b000;
      off_q     <= 2'b00;
      wdata_q   <= 16'h0;
      rdata_q   <= 32'h0;
      raddr_q   <= 32'h0;
      waddr_q   <= 32'h0;
      dataout_q <= 32'h0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      store_q   <= store_d;
      size_q    <= size_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      dataout_q <= dataout_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
    end
  end

  assign rdata_o       = rdata_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign busy_o        = (state_q != S_IDLE);
  assign mem_raddr_o   = raddr_q;
  assign mem_waddr_o   = waddr_q;
  assign mem_dataout_o = dataout_q;
  assign mem_wr_o      = wr_q;

endmodule
